// File: rtl/phase_timer.sv
// Phase countdown timer: 1 s prescaler, saturating down-counter with clamped loads
// and optional green-phase extension (compiled in with PHASE_TIMER_EXT_EN).
module phase_timer #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned RESET_VALUE = 30,
  parameter int unsigned MAX_VALUE   = 31,
  parameter int unsigned GREEN_MIN   = 4,
  parameter int unsigned EXT_STEP    = 5,
  parameter int unsigned MAX_EXT     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_counter,
  input  logic [4:0] load_value,
  input  logic       freeze,
  input  logic       ext_req,
  output logic [4:0] counter_value,
  output logic       tick,
  output logic       expired,
  output logic       load_ack,
  output logic       ext_granted
);

  localparam int unsigned CW = 5;
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned AW = 8;

  logic [PW-1:0] presc_q;
  logic          presc_top;
  logic [AW-1:0] load_wide;
  logic [CW-1:0] load_clamp;
  logic [CW-1:0] cnt_run;
  logic          ext_ok;
  logic [CW-1:0] ext_val;

  assign presc_top = (presc_q == PW'(TICK_DIV - 1));
  assign tick      = presc_top & ~freeze;
  assign expired   = (counter_value == CW'(1));

  // Load value clamped into 1..MAX_VALUE; zero is promoted to 1
  always_comb begin
    load_wide  = AW'(load_value);
    load_clamp = load_value;
    if (load_wide == '0) begin
      load_clamp = CW'(1);
    end else if (load_wide > AW'(MAX_VALUE)) begin
      load_clamp = CW'(MAX_VALUE);
    end
  end

  // Running counter: extension takes precedence over a plain decrement
  always_comb begin
    cnt_run = counter_value;
    if (ext_ok) begin
      cnt_run = ext_val;
    end else if (tick && (counter_value > CW'(1))) begin
      cnt_run = counter_value - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter_value <= CW'(RESET_VALUE);
      presc_q       <= '0;
      load_ack      <= 1'b0;
    end else begin
      load_ack <= load_counter;
      if (load_counter) begin
        counter_value <= load_clamp;
        presc_q       <= '0;
      end else if (!freeze) begin
        counter_value <= cnt_run;
        presc_q       <= presc_top ? '0 : presc_q + PW'(1);
      end
    end
  end

`ifdef PHASE_TIMER_EXT_EN
  localparam int unsigned EW = (MAX_EXT > 0) ? $clog2(MAX_EXT + 1) : 1;

  logic          ext_prev_q;
  logic [EW-1:0] ext_cnt_q;
  logic          green_q;
  logic          ext_edge;
  logic [AW-1:0] ext_sum;

  assign ext_edge = ext_req & ~ext_prev_q;
  assign ext_ok   = ext_edge && green_q && (counter_value > CW'(1)) &&
                    (AW'(ext_cnt_q) < AW'(MAX_EXT)) && !freeze && !load_counter;

  // Wide sum so the ceiling check sees values above 31
  always_comb begin
    ext_sum = AW'(counter_value) - AW'(tick) + AW'(EXT_STEP);
    ext_val = (ext_sum > AW'(MAX_VALUE)) ? CW'(MAX_VALUE) : CW'(ext_sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_prev_q  <= 1'b0;
      ext_cnt_q   <= '0;
      green_q     <= (RESET_VALUE >= GREEN_MIN);
      ext_granted <= 1'b0;
    end else begin
      ext_prev_q  <= ext_req;
      ext_granted <= ext_ok;
      if (load_counter) begin
        ext_cnt_q <= '0;
        green_q   <= (AW'(load_clamp) >= AW'(GREEN_MIN));
      end else if (ext_ok) begin
        ext_cnt_q <= ext_cnt_q + EW'(1);
      end
    end
  end
`else
  localparam int unsigned UNUSED_EXT_CFG = GREEN_MIN + EXT_STEP + MAX_EXT;
  logic unused_ext_req;

  assign unused_ext_req = ext_req;
  assign ext_ok         = 1'b0;
  assign ext_val        = counter_value;
  assign ext_granted    = 1'b0;
`endif

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer with a behavioural reference model and literal anchors.
module tb_phase_timer;

  localparam int TD   = 4;
  localparam int RV   = 30;
  localparam int MAXV = 31;
  localparam int GMIN = 4;
  localparam int STEP = 5;
  localparam int MAXE = 2;
`ifdef PHASE_TIMER_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_counter;
  logic [4:0] load_value;
  logic       freeze;
  logic       ext_req;
  logic [4:0] counter_value;
  logic       tick;
  logic       expired;
  logic       load_ack;
  logic       ext_granted;

  int vectors = 0;
  int errors  = 0;

  // Model: remaining seconds, active cycles since phase start, extension bookkeeping
  int m_cnt, m_since, m_exts, m_green, m_prev, m_ack, m_grant;

  phase_timer #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .load_counter(load_counter), .load_value(load_value),
    .freeze(freeze), .ext_req(ext_req), .counter_value(counter_value), .tick(tick),
    .expired(expired), .load_ack(load_ack), .ext_granted(ext_granted)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = RV; m_since = 0; m_exts = 0; m_green = (RV >= GMIN) ? 1 : 0;
    m_prev = 0; m_ack = 0; m_grant = 0;
  endtask

  task automatic model_advance(input bit tk);
    int v;
    bit rise;
    rise = ext_req && (m_prev == 0);
    m_ack = 0; m_grant = 0;
    if (load_counter) begin
      v = int'(load_value);
      if (v == 0) v = 1;
      if (v > MAXV) v = MAXV;
      m_cnt = v; m_since = 0; m_exts = 0; m_green = (v >= GMIN) ? 1 : 0; m_ack = 1;
    end else if (!freeze) begin
      m_since++;
      if (EXT && rise && m_green == 1 && m_cnt > 1 && m_exts < MAXE) begin
        v = m_cnt - (tk ? 1 : 0) + STEP;
        m_cnt = (v > MAXV) ? MAXV : v;
        m_exts++;
        m_grant = 1;
      end else if (tk && m_cnt > 1) begin
        m_cnt--;
      end
    end
    m_prev = ext_req ? 1 : 0;
  endtask

  // One clock: compare outputs, advance model across the edge, return at negedge
  task automatic step();
    bit exp_tick;
    #1;
    if (!rst_n) model_reset();
    exp_tick = rst_n && !freeze && ((m_since % TD) == TD - 1);
    check_val("counter_value", int'(counter_value), m_cnt);
    check_val("tick", int'(tick), int'(exp_tick));
    check_val("expired", int'(expired), (m_cnt == 1) ? 1 : 0);
    check_val("load_ack", int'(load_ack), m_ack);
    check_val("ext_granted", int'(ext_granted), m_grant);
    @(posedge clk);
    if (rst_n) model_advance(exp_tick);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input int v);
    load_counter = 1'b1;
    load_value   = 5'(v);
    run(1);
    load_counter = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_counter = 1'b0; load_value = '0; freeze = 1'b0; ext_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    run(2);
    check_val("lit_reset_cnt", int'(counter_value), 30);
    rst_n = 1'b1;

    // Free-running countdown from reset value to the floor
    run(115);
    check_val("lit_cnt_before_floor", int'(counter_value), 2);
    run(1);
    check_val("lit_cnt_floor", int'(counter_value), 1);
    check_val("lit_expired", int'(expired), 1);
    run(8);
    check_val("lit_hold_floor", int'(counter_value), 1);

    do_load(3);
    check_val("lit_load3", int'(counter_value), 3);
    check_val("lit_load3_ack", int'(load_ack), 1);
    run(4);
    check_val("lit_load3_dec1", int'(counter_value), 2);
    run(4);
    check_val("lit_load3_dec2", int'(counter_value), 1);

    do_load(0);
    check_val("lit_load0", int'(counter_value), 1);
    do_load(31);
    check_val("lit_load31", int'(counter_value), 31);

    // Freeze mid-second at counter 12
    do_load(15);
    run(12);
    check_val("lit_pre_freeze", int'(counter_value), 12);
    run(2);
    freeze = 1'b1;
    run(10);
    check_val("lit_frozen", int'(counter_value), 12);
    freeze = 1'b0;
    run(1);
    check_val("lit_thaw1", int'(counter_value), 12);
    run(1);
    check_val("lit_thaw2", int'(counter_value), 11);

    // Extension requests on a green phase of 10
    do_load(10);
    ext_req = 1'b1; run(1);
    check_val("lit_ext1", int'(counter_value), EXT ? 15 : 10);
    check_val("lit_ext1_grant", int'(ext_granted), EXT ? 1 : 0);
    ext_req = 1'b0; run(1);
    ext_req = 1'b1; run(1);
    check_val("lit_ext2", int'(counter_value), EXT ? 20 : 10);
    ext_req = 1'b0; run(1);
    check_val("lit_ext2_tick", int'(counter_value), EXT ? 19 : 9);
    ext_req = 1'b1; run(1);
    check_val("lit_ext3_dropped", int'(counter_value), EXT ? 19 : 9);
    check_val("lit_ext3_grant", int'(ext_granted), 0);
    ext_req = 1'b0; run(1);

    // Request edge coincident with a load
    load_counter = 1'b1; load_value = 5'd10; ext_req = 1'b1;
    run(1);
    load_counter = 1'b0;
    check_val("lit_coinc_cnt", int'(counter_value), 10);
    check_val("lit_coinc_grant", int'(ext_granted), 0);
    run(1);
    check_val("lit_coinc_held", int'(counter_value), 10);
    ext_req = 1'b0;

    // Extension on a tick cycle at 29 saturates
    do_load(29);
    run(3);
    ext_req = 1'b1; run(1);
    check_val("lit_sat", int'(counter_value), EXT ? 31 : 28);
    check_val("lit_sat_grant", int'(ext_granted), EXT ? 1 : 0);
    ext_req = 1'b0;
    run(2);

    // Reset mid-phase
    rst_n = 1'b0;
    run(2);
    check_val("lit_midreset", int'(counter_value), 30);
    rst_n = 1'b1;
    run(4);
    check_val("lit_post_reset_tick", int'(counter_value), 29);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
